// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multicycle MIPS-subset control path.
//   - opcode values of the supported instruction subset (IR[31:26])
//   - 3-bit ALU class codes driven on `uc` to the ALU decoder
//   - controller state encoding (also visible on state_o for debug)
//   - small decode helpers used by the controller
// ---------------------------------------------------------------------------
package mips_pkg;

    // Opcodes of the supported subset
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // ALU class codes; UC_RTYPE defers to the funct field
    localparam logic [2:0] UC_ADD   = 3'b000;
    localparam logic [2:0] UC_SUB   = 3'b001;
    localparam logic [2:0] UC_SLT   = 3'b010;
    localparam logic [2:0] UC_AND   = 3'b101;
    localparam logic [2:0] UC_OR    = 3'b110;
    localparam logic [2:0] UC_RTYPE = 3'b111;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_R_EXEC   = 4'd3,
        ST_R_WB     = 4'd4,
        ST_I_EXEC   = 4'd5,
        ST_I_WB     = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_MEM_WB   = 4'd9,
        ST_MEM_WR   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_TRAP     = 4'd13
    } state_t;

    // States that hold a memory request open until mem_ready
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

    // ALU class for the immediate arithmetic/logic instructions
    function automatic logic [2:0] imm_uc(input logic [5:0] op);
        case (op)
            OP_ANDI: return UC_AND;
            OP_ORI:  return UC_OR;
            OP_SLTI: return UC_SLT;
            default: return UC_ADD;
        endcase
    endfunction

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting on memory and flags the cycle in which the
// wait budget is used up.
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clr        restart the count (entry to a memory state)
//   i_inc        one more cycle waited (memory state, mem_ready low)
//   o_expired    this waiting cycle is the MEM_TIMEOUT-th one
// Parameters: MEM_TIMEOUT (0 = never expire), TO_W (2^TO_W > MEM_TIMEOUT).
// ---------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam logic             LP_ENABLED = (MEM_TIMEOUT != 0);
    localparam logic [TO_W-1:0]  LP_LAST    = TO_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
    localparam logic [TO_W-1:0]  LP_MAX     = '1;

    logic [TO_W-1:0] r_count;

    // Expiry is flagged in the waiting cycle that brings the count to
    // MEM_TIMEOUT, so the controller aborts on that same clock edge.
    assign o_expired = LP_ENABLED && i_inc && (r_count == LP_LAST);

    // Saturate so a disabled timeout cannot wrap into a false expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != LP_MAX)) begin
            r_count <= r_count + TO_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for the multicycle MIPS-subset datapath: fetch, decode,
// execute, memory and writeback, with a memory request/ready handshake and
// a memory wait timeout.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   en               run enable, only looked at on instruction boundaries
//   opcode           IR[31:26]
//   zero             ALU zero flag (beq)
//   mem_ready        memory completes the current access this cycle
//   mem_req, iord    memory request and address select (0 PC, 1 ALUOut)
//   mem_write        store strobe, valid with mem_req
//   ir_write, pc_write, pc_source   IR/PC update controls
//   alu_src_a, alu_src_b, uc        ALU operand selects and ALU class
//   reg_dst, mem_to_reg, reg_write  register file write controls
//   instr_done       one-cycle pulse when an instruction retires
//   mem_err          sticky memory timeout flag (cleared by reset only)
//   state_o          current state, for debug
//   illegal          sticky illegal-opcode flag (trap build only)
//
// Build option MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: unknown opcodes enter a
// TRAP state that holds until reset and raise `illegal`. When undefined,
// unknown opcodes retire from DECODE as a NOP.
//
// Memory handshake: mem_req is the valid, mem_ready the ready. An access
// completes in the cycle both are high; until then mem_req, iord and
// mem_write stay constant. mem_ready without mem_req is ignored.
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] uc,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic       mem_err,
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic [3:0] state_o
);

    state_t r_state;
    state_t w_next_state;
    state_t w_retire_state;
    logic   r_mem_err;
    logic   w_tmr_clr;
    logic   w_tmr_inc;
    logic   w_expired;

    // ---------------- wait timer ----------------
    assign w_tmr_inc = is_mem_state(r_state) && !mem_ready;
    assign w_tmr_clr = (w_next_state != r_state) && is_mem_state(w_next_state);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_mem_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_tmr_clr),
        .i_inc     (w_tmr_inc),
        .o_expired (w_expired)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_err <= 1'b0;
        end else if (w_expired) begin
            r_mem_err <= 1'b1;
        end
    end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;

    // Raised on the edge that enters TRAP so it lines up with state_o
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (w_next_state == ST_TRAP) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`endif

    assign mem_err = r_mem_err;
    assign state_o = r_state;

    // ---------------- next-state logic ----------------
    always_comb begin
        // en is only consulted here, on the instruction boundary
        w_retire_state = en ? ST_FETCH : ST_IDLE;
        w_next_state   = r_state;
        case (r_state)
            ST_IDLE:     w_next_state = en ? ST_FETCH : ST_IDLE;
            ST_FETCH: begin
                if (w_expired)      w_next_state = ST_IDLE;
                else if (mem_ready) w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:                          w_next_state = ST_R_EXEC;
                    OP_LW, OP_SW:                      w_next_state = ST_MEM_ADDR;
                    OP_BEQ:                            w_next_state = ST_BRANCH;
                    OP_J:                              w_next_state = ST_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next_state = ST_I_EXEC;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    default:                           w_next_state = ST_TRAP;
`else
                    default:                           w_next_state = w_retire_state;
`endif
                endcase
            end
            ST_R_EXEC:   w_next_state = ST_R_WB;
            ST_I_EXEC:   w_next_state = ST_I_WB;
            ST_MEM_ADDR: w_next_state = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (w_expired)      w_next_state = ST_IDLE;
                else if (mem_ready) w_next_state = ST_MEM_WB;
            end
            ST_MEM_WR: begin
                if (w_expired)      w_next_state = ST_IDLE;
                else if (mem_ready) w_next_state = w_retire_state;
            end
            ST_R_WB, ST_I_WB, ST_MEM_WB,
            ST_BRANCH, ST_JUMP:  w_next_state = w_retire_state;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            ST_TRAP:     w_next_state = ST_TRAP;
`endif
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        uc         = UC_ADD;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                // PC+4 and IR commit only when the fetch completes
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = 2'b11;
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                instr_done = !is_legal_op(opcode);
`endif
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                uc        = UC_RTYPE;
            end
            ST_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                uc        = imm_uc(opcode);
            end
            ST_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ST_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            ST_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            ST_BRANCH: begin
                alu_src_a  = 1'b1;
                uc         = UC_SUB;
                pc_source  = 2'b01;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            ST_JUMP: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. Each scenario pushes one
// stimulus word and one expected output word per cycle, then replays the
// stimulus and compares the DUT against the expected queue.
// Expected word: {illegal, mem_err, state, req, iord, mem_write, ir_write,
//                 pc_write, pc_source, alu_src_a, alu_src_b, uc,
//                 reg_dst, mem_to_reg, reg_write, instr_done}
// Stimulus word: {en, zero, mem_ready, opcode}
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
    import mips_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    always #5 clk = ~clk;

    logic       mem_req, iord, mem_write, ir_write, pc_write;
    logic [1:0] pc_source, alu_src_b;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done, mem_err;
    logic [2:0] uc;
    logic [3:0] state_o;
    logic       ill_bit;

    multicycle_ctrl #(
        .MEM_TIMEOUT (4),
        .TO_W        (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .uc         (uc),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .instr_done (instr_done),
        .mem_err    (mem_err),
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        .illegal    (ill_bit),
`endif
        .state_o    (state_o)
    );

`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    assign ill_bit = 1'b0;
`endif

    logic [22:0] obs;
    assign obs = {ill_bit, mem_err, state_o, mem_req, iord, mem_write, ir_write,
                  pc_write, pc_source, alu_src_a, alu_src_b, uc,
                  reg_dst, mem_to_reg, reg_write, instr_done};

    // ---------------- scoreboard ----------------
    logic [8:0]  stim_q[$];
    logic [22:0] exp_q[$];
    logic        exp_err = 1'b0;
    logic        exp_ill = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Expected word; the sticky flags come from the bench's own tracking
    function automatic logic [22:0] v(input logic [3:0] st, input logic [4:0] mem5,
                                      input logic [1:0] pcs, input logic asa,
                                      input logic [1:0] asb, input logic [2:0] u,
                                      input logic [3:0] wb4);
        return {exp_ill, exp_err, st, mem5, pcs, asa, asb, u, wb4};
    endfunction

    function automatic logic [22:0] e_idle();
        return v(ST_IDLE, 5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000);
    endfunction

    function automatic logic [22:0] e_fetch(input logic rdy);
        return v(ST_FETCH, {3'b100, rdy, rdy}, 2'b00, 1'b0, 2'b01, 3'b000, 4'b0000);
    endfunction

    function automatic logic [22:0] e_decode(input logic done);
        return v(ST_DECODE, 5'b00000, 2'b00, 1'b0, 2'b11, 3'b000, {3'b000, done});
    endfunction

    function automatic logic [8:0] s(input logic e, input logic z, input logic r,
                                     input logic [5:0] op);
        return {e, z, r, op};
    endfunction

    // ---------------- driver ----------------
    task automatic push(input logic [8:0] st, input logic [22:0] ex);
        stim_q.push_back(st);
        exp_q.push_back(ex);
    endtask

    // Apply one cycle of stimulus just after the rising edge, sample at the falling edge
    task automatic drive_cycle(input logic [8:0] st);
        @(posedge clk);
        #1;
        {en, zero, mem_ready, opcode} = st;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (obs !== e_idle()) begin
            n_bad++;
            $display("FAIL reset_hold: got %h want %h", obs, e_idle());
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== e_idle()) begin
            n_bad++;
            $display("FAIL reset_release: got %h want %h", obs, e_idle());
        end
    endtask

    task automatic test_rtype();
        logic [22:0] exp_v;
        int cyc = 0;
        push(s(1, 0, 1, 6'b000000), e_idle());
        push(s(0, 0, 1, 6'b000000), e_fetch(1'b1));   // en dropped mid-instruction: ignored
        push(s(0, 0, 1, 6'b000000), e_decode(1'b0));
        push(s(0, 0, 1, 6'b000000), v(ST_R_EXEC, 5'b00000, 2'b00, 1'b1, 2'b00, 3'b111, 4'b0000));
        push(s(0, 0, 1, 6'b000000), v(ST_R_WB, 5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b1011));
        while (exp_q.size() != 0) begin
            drive_cycle(stim_q.pop_front());
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL rtype cyc%0d: got %h want %h", cyc, obs, exp_v);
            end
            cyc++;
        end
    endtask

    task automatic test_itype();
        logic [22:0] exp_v;
        logic [5:0] ops[4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
        logic [2:0] ucs[4] = '{3'b000, 3'b101, 3'b110, 3'b010};
        for (int k = 0; k < 4; k++) begin
            push(s(1, 0, 1, ops[k]), e_idle());
            push(s(0, 0, 1, ops[k]), e_fetch(1'b1));
            push(s(0, 0, 1, ops[k]), e_decode(1'b0));
            push(s(0, 0, 1, ops[k]), v(ST_I_EXEC, 5'b00000, 2'b00, 1'b1, 2'b10, ucs[k], 4'b0000));
            push(s(0, 0, 1, ops[k]), v(ST_I_WB, 5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0011));
            for (int c = 0; exp_q.size() != 0; c++) begin
                drive_cycle(stim_q.pop_front());
                exp_v = exp_q.pop_front();
                n_cmp++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL itype op=%b cyc%0d: got %h want %h", ops[k], c, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [22:0] exp_v;
        int cyc = 0;
        push(s(1, 0, 1, 6'b000000), e_idle());
        push(s(0, 0, 1, 6'b000000), e_fetch(1'b1));
        push(s(0, 0, 1, 6'b000000), e_decode(1'b0));
        push(s(0, 0, 1, 6'b000000), v(ST_R_EXEC, 5'b00000, 2'b00, 1'b1, 2'b00, 3'b111, 4'b0000));
        push(s(1, 0, 1, 6'b000000), v(ST_R_WB, 5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b1011));
        push(s(0, 0, 1, 6'b001101), e_fetch(1'b1));   // straight into the next fetch
        push(s(0, 0, 1, 6'b001101), e_decode(1'b0));
        push(s(0, 0, 1, 6'b001101), v(ST_I_EXEC, 5'b00000, 2'b00, 1'b1, 2'b10, 3'b110, 4'b0000));
        push(s(0, 0, 1, 6'b001101), v(ST_I_WB, 5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0011));
        while (exp_q.size() != 0) begin
            drive_cycle(stim_q.pop_front());
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", cyc, obs, exp_v);
            end
            cyc++;
        end
    endtask

    task automatic test_lw_wait();
        logic [22:0] exp_v;
        int cyc = 0;
        push(s(1, 0, 1, 6'b100011), e_idle());
        push(s(0, 0, 1, 6'b100011), e_fetch(1'b1));
        push(s(0, 0, 1, 6'b100011), e_decode(1'b0));
        // ready without a request must not matter
        push(s(0, 0, 1, 6'b100011), v(ST_MEM_ADDR, 5'b00000, 2'b00, 1'b1, 2'b10, 3'b000, 4'b0000));
        for (int w = 0; w < 3; w++)
            push(s(0, 0, 0, 6'b100011), v(ST_MEM_RD, 5'b11000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000));
        push(s(0, 0, 1, 6'b100011), v(ST_MEM_RD, 5'b11000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000));
        push(s(0, 0, 0, 6'b100011), v(ST_MEM_WB, 5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0111));
        while (exp_q.size() != 0) begin
            drive_cycle(stim_q.pop_front());
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL lw_wait cyc%0d: got %h want %h", cyc, obs, exp_v);
            end
            cyc++;
        end
    endtask

    task automatic test_sw();
        logic [22:0] exp_v;
        int cyc = 0;
        push(s(1, 0, 0, 6'b101011), e_idle());
        push(s(0, 0, 1, 6'b101011), e_fetch(1'b1));
        push(s(0, 0, 0, 6'b101011), e_decode(1'b0));
        push(s(0, 0, 0, 6'b101011), v(ST_MEM_ADDR, 5'b00000, 2'b00, 1'b1, 2'b10, 3'b000, 4'b0000));
        push(s(0, 0, 0, 6'b101011), v(ST_MEM_WR, 5'b11100, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000));
        push(s(0, 0, 1, 6'b101011), v(ST_MEM_WR, 5'b11100, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0001));
        push(s(0, 0, 0, 6'b101011), e_idle());
        while (exp_q.size() != 0) begin
            drive_cycle(stim_q.pop_front());
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL sw cyc%0d: got %h want %h", cyc, obs, exp_v);
            end
            cyc++;
        end
    endtask

    task automatic test_beq();
        logic [22:0] exp_v;
        for (int zi = 0; zi < 2; zi++) begin
            logic z = (zi == 0);
            push(s(1, !z, 1, 6'b000100), e_idle());
            push(s(0, !z, 1, 6'b000100), e_fetch(1'b1));
            push(s(0, !z, 1, 6'b000100), e_decode(1'b0));
            push(s(0, z, 1, 6'b000100),
                 v(ST_BRANCH, {4'b0000, z}, 2'b01, 1'b1, 2'b00, 3'b001, 4'b0001));
            for (int c = 0; exp_q.size() != 0; c++) begin
                drive_cycle(stim_q.pop_front());
                exp_v = exp_q.pop_front();
                n_cmp++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL beq zero=%0d cyc%0d: got %h want %h", z, c, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_jump();
        logic [22:0] exp_v;
        int cyc = 0;
        push(s(1, 0, 1, 6'b000010), e_idle());
        push(s(0, 0, 1, 6'b000010), e_fetch(1'b1));
        push(s(0, 0, 1, 6'b000010), e_decode(1'b0));
        push(s(0, 0, 1, 6'b000010), v(ST_JUMP, 5'b00001, 2'b10, 1'b0, 2'b00, 3'b000, 4'b0001));
        while (exp_q.size() != 0) begin
            drive_cycle(stim_q.pop_front());
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL jump cyc%0d: got %h want %h", cyc, obs, exp_v);
            end
            cyc++;
        end
    endtask

    // MEM_TIMEOUT = 4: the fourth waiting fetch cycle aborts to IDLE
    task automatic test_timeout();
        logic [22:0] exp_v;
        int cyc = 0;
        push(s(1, 0, 0, 6'b000000), e_idle());
        for (int w = 0; w < 4; w++)
            push(s(0, 0, 0, 6'b000000), e_fetch(1'b0));
        exp_err = 1'b1;
        push(s(0, 0, 0, 6'b000000), e_idle());
        push(s(0, 0, 1, 6'b000000), e_idle());
        while (exp_q.size() != 0) begin
            drive_cycle(stim_q.pop_front());
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL timeout cyc%0d: got %h want %h", cyc, obs, exp_v);
            end
            cyc++;
        end
    endtask

    task automatic test_illegal();
        logic [22:0] exp_v;
        int cyc = 0;
        push(s(1, 0, 1, 6'b111111), e_idle());
        push(s(0, 0, 1, 6'b111111), e_fetch(1'b1));
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        push(s(1, 0, 1, 6'b111111), e_decode(1'b0));
        exp_ill = 1'b1;
        for (int t = 0; t < 3; t++)
            push(s(1, 1, 1, 6'b111111), v(ST_TRAP, 5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000));
`else
        push(s(1, 0, 1, 6'b111111), e_decode(1'b1));
        push(s(0, 0, 1, 6'b111111), e_fetch(1'b1));
        push(s(0, 0, 1, 6'b111111), e_decode(1'b1));
        push(s(0, 0, 1, 6'b111111), e_idle());
`endif
        while (exp_q.size() != 0) begin
            drive_cycle(stim_q.pop_front());
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL illegal cyc%0d: got %h want %h", cyc, obs, exp_v);
            end
            cyc++;
        end
    endtask

    task automatic test_reset_mid_lw();
        logic [22:0] exp_v;
        int cyc = 0;
        // A prior TRAP would hold, so a reset brings the DUT back first
        rst_n = 1'b0;
        exp_err = 1'b0;
        exp_ill = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        push(s(1, 0, 1, 6'b100011), e_idle());
        push(s(0, 0, 1, 6'b100011), e_fetch(1'b1));
        push(s(0, 0, 1, 6'b100011), e_decode(1'b0));
        push(s(0, 0, 0, 6'b100011), v(ST_MEM_ADDR, 5'b00000, 2'b00, 1'b1, 2'b10, 3'b000, 4'b0000));
        push(s(0, 0, 0, 6'b100011), v(ST_MEM_RD, 5'b11000, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000));
        while (exp_q.size() != 0) begin
            drive_cycle(stim_q.pop_front());
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL reset_mid_lw cyc%0d: got %h want %h", cyc, obs, exp_v);
            end
            cyc++;
        end
        // Asynchronous: takes effect between clock edges
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== e_idle()) begin
            n_bad++;
            $display("FAIL reset_async: got %h want %h", obs, e_idle());
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== e_idle()) begin
            n_bad++;
            $display("FAIL reset_async_release: got %h want %h", obs, e_idle());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_back_to_back();
        test_lw_wait();
        test_beq();
        test_jump();
        test_sw();
        test_timeout();
        test_illegal();
        test_reset_mid_lw();
        test_rtype();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
